reg_access_ctrl: RTL and testbench

Sequencer that owns the single shared port of the 8×16-bit register file. It accepts operand-read requests from decode and writeback requests from execute, buffers writebacks in a 2-entry queue, and serializes both onto the register file's `rs`/`rd`/`readflag`/`value` interface. Raw-hazard ordering is enforced, so a read never returns a value older than an accepted writeback to the same register. The block sits between the pipeline control and the register file; it is the only driver of the register file inputs.

---
 rtl/reg_access_ctrl_if.sv | 35 +++
 rtl/reg_access_ctrl.sv | 130 +++++++++++++
 tb/tb_reg_access_ctrl.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/reg_access_ctrl_if.sv
// Bundle of decode read, execute writeback and register-file port signals
// around reg_access_ctrl. slave is the controller's view, master the surroundings'.
interface reg_access_ctrl_if;
  logic        rd_req_valid;
  logic        rd_req_ready;
  logic [2:0]  rd_addr_a;
  logic [2:0]  rd_addr_b;
  logic        rd_rsp_valid;
  logic [15:0] rd_data_a;
  logic [15:0] rd_data_b;
  logic        wb_valid;
  logic        wb_ready;
  logic [2:0]  wb_addr;
  logic [15:0] wb_data;
  logic [2:0]  rf_rs;
  logic [2:0]  rf_rd;
  logic        rf_readflag;
  logic [15:0] rf_value;
  logic [15:0] rf_read1;
  logic [15:0] rf_read2;

  modport slave (
    input  rd_req_valid, rd_addr_a, rd_addr_b, wb_valid, wb_addr, wb_data,
           rf_read1, rf_read2,
    output rd_req_ready, rd_rsp_valid, rd_data_a, rd_data_b, wb_ready,
           rf_rs, rf_rd, rf_readflag, rf_value
  );

  modport master (
    output rd_req_valid, rd_addr_a, rd_addr_b, wb_valid, wb_addr, wb_data,
           rf_read1, rf_read2,
    input  rd_req_ready, rd_rsp_valid, rd_data_a, rd_data_b, wb_ready,
           rf_rs, rf_rd, rf_readflag, rf_value
  );
endinterface

// File: rtl/reg_access_ctrl.sv
// Serializes operand reads and queued writebacks onto the single register-file port.
// Optional REG_ACCESS_WB_BYPASS_EN writes straight through when the queue is empty.
module reg_access_ctrl #(
  parameter int unsigned QDEPTH = 2
) (
  input logic              clock,
  input logic              reset_n,
  reg_access_ctrl_if.slave bus
);

  localparam int unsigned PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int unsigned CW = PW + 1;

  typedef enum logic [1:0] {ActIdle, ActRead, ActWrite, ActBypass} action_e;

  logic [2:0]        addr_q [QDEPTH];
  logic [15:0]       data_q [QDEPTH];
  logic [QDEPTH-1:0] vld_q, vld_d;
  logic [PW-1:0]     head_q, head_d, tail_q, tail_d;
  logic [CW-1:0]     count_q, count_d;
  logic              rsp_q;

  logic    full, empty, hazard, push, pop;
  action_e action;

  assign full  = (count_q == CW'(QDEPTH));
  assign empty = (count_q == '0);

  // Only entries already in the queue take part; a same-cycle writeback does not.
  always_comb begin
    hazard = 1'b0;
    for (int i = 0; i < int'(QDEPTH); i++) begin
      if (vld_q[i] && (addr_q[i] == bus.rd_addr_a || addr_q[i] == bus.rd_addr_b)) begin
        hazard = 1'b1;
      end
    end
  end

  always_comb begin
    action = ActIdle;
    if (reset_n && bus.rd_req_valid && !full && !hazard) begin
      action = ActRead;
    end else if (!empty) begin
      action = ActWrite;
`ifdef REG_ACCESS_WB_BYPASS_EN
    end else if (reset_n && bus.wb_valid) begin
      action = ActBypass;
`endif
    end
  end

  always_comb begin
    bus.rd_req_ready = 1'b0;
    bus.rf_readflag  = 1'b1;
    bus.rf_rs        = 3'd0;
    bus.rf_rd        = 3'd0;
    bus.rf_value     = 16'd0;
    unique case (action)
      ActRead: begin
        bus.rd_req_ready = 1'b1;
        bus.rf_rs        = bus.rd_addr_a;
        bus.rf_rd        = bus.rd_addr_b;
      end
      ActWrite: begin
        bus.rf_readflag = 1'b0;
        bus.rf_rs       = addr_q[head_q];
        bus.rf_value    = data_q[head_q];
      end
      ActBypass: begin
        bus.rf_readflag = 1'b0;
        bus.rf_rs       = bus.wb_addr;
        bus.rf_value    = bus.wb_data;
      end
      default: ;
    endcase
  end

  assign bus.wb_ready     = reset_n && !full;
  assign bus.rd_rsp_valid = rsp_q;
  assign bus.rd_data_a    = bus.rf_read1;
  assign bus.rd_data_b    = bus.rf_read2;

  assign push = bus.wb_valid && bus.wb_ready && (action != ActBypass);
  assign pop  = (action == ActWrite);

  always_comb begin
    vld_d  = vld_q;
    head_d = head_q;
    tail_d = tail_q;
    count_d = count_q;
    if (pop) begin
      vld_d[head_q] = 1'b0;
      head_d        = head_q + PW'(1);
    end
    if (push) begin
      vld_d[tail_q] = 1'b1;
      tail_d        = tail_q + PW'(1);
    end
    if (push && !pop) begin
      count_d = count_q + CW'(1);
    end else if (pop && !push) begin
      count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      vld_q   <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      rsp_q   <= 1'b0;
    end else begin
      vld_q   <= vld_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      rsp_q   <= (action == ActRead);
    end
  end

  // Payload storage needs no reset; validity is tracked by vld_q.
  always_ff @(posedge clock) begin
    if (push) begin
      addr_q[tail_q] <= bus.wb_addr;
      data_q[tail_q] <= bus.wb_data;
    end
  end

endmodule

// File: tb/tb_reg_access_ctrl.sv
// Directed table-driven bench for reg_access_ctrl with a behavioural 8x16 register file.
module tb_reg_access_ctrl;

  logic clock;
  logic reset_n;
  reg_access_ctrl_if bus ();

  reg_access_ctrl #(.QDEPTH(2)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  logic [15:0] regs [8] = '{default: 16'h0000};
  initial begin
    bus.rf_read1 = 16'h0;
    bus.rf_read2 = 16'h0;
  end
  always @(posedge clock) begin
    if (!bus.rf_readflag) begin
      regs[bus.rf_rs] <= bus.rf_value;
    end else begin
      bus.rf_read1 <= regs[bus.rf_rs];
      bus.rf_read2 <= regs[bus.rf_rd];
    end
  end

  typedef struct {
    logic        rv;
    logic [2:0]  a;
    logic [2:0]  b;
    logic        wv;
    logic [2:0]  wa;
    logic [15:0] wd;
    logic        e_rdy;
    logic        e_wrdy;
    logic        e_flag;
    logic [2:0]  e_rs;
    logic [2:0]  e_rd;
    logic [15:0] e_val;
    logic        e_rsp;
    logic [15:0] e_da;
    logic [15:0] e_db;
  } vec_t;

  vec_t vq[$];
  int checks = 0;
  int failures = 0;
  int step = -1;

  function automatic vec_t mk(logic rv, logic [2:0] a, logic [2:0] b, logic wv, logic [2:0] wa,
                              logic [15:0] wd, logic rdy, logic wrdy, logic flag, logic [2:0] rs,
                              logic [2:0] rd, logic [15:0] val, logic rsp, logic [15:0] da,
                              logic [15:0] db);
    vec_t v;
    v = '{rv, a, b, wv, wa, wd, rdy, wrdy, flag, rs, rd, val, rsp, da, db};
    return v;
  endfunction

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s step %0d: got %h expected %h", name, step, act, exp);
    end
  endtask

  task automatic drive(input logic rv, input logic [2:0] a, input logic [2:0] b, input logic wv,
                       input logic [2:0] wa, input logic [15:0] wd);
    bus.rd_req_valid = rv;
    bus.rd_addr_a    = a;
    bus.rd_addr_b    = b;
    bus.wb_valid     = wv;
    bus.wb_addr      = wa;
    bus.wb_data      = wd;
  endtask

  task automatic check_port(input vec_t v);
    chk("rd_req_ready", 16'(bus.rd_req_ready), 16'(v.e_rdy));
    chk("wb_ready", 16'(bus.wb_ready), 16'(v.e_wrdy));
    chk("rf_readflag", 16'(bus.rf_readflag), 16'(v.e_flag));
    chk("rf_rs", 16'(bus.rf_rs), 16'(v.e_rs));
    chk("rf_rd", 16'(bus.rf_rd), 16'(v.e_rd));
    chk("rf_value", bus.rf_value, v.e_val);
    chk("rd_rsp_valid", 16'(bus.rd_rsp_valid), 16'(v.e_rsp));
    if (v.e_rsp) begin
      chk("rd_data_a", bus.rd_data_a, v.e_da);
      chk("rd_data_b", bus.rd_data_b, v.e_db);
    end
  endtask

  initial begin
    //        rv a  b  wv wa wd        rdy wrdy flag rs rd val       rsp da        db
    vq.push_back(mk(0, 0, 0, 0, 0, 16'h0,    0, 1, 1, 0, 0, 16'h0,    0, 16'h0,    16'h0));
    vq.push_back(mk(0, 0, 0, 1, 3, 16'h1234, 0, 1, 1, 0, 0, 16'h0,    0, 16'h0,    16'h0));
    vq.push_back(mk(1, 3, 0, 0, 0, 16'h0,    0, 1, 0, 3, 0, 16'h1234, 0, 16'h0,    16'h0));
    vq.push_back(mk(1, 3, 0, 0, 0, 16'h0,    1, 1, 1, 3, 0, 16'h0,    0, 16'h0,    16'h0));
    vq.push_back(mk(0, 0, 0, 0, 0, 16'h0,    0, 1, 1, 0, 0, 16'h0,    1, 16'h1234, 16'h0));
    vq.push_back(mk(1, 5, 6, 1, 1, 16'h1111, 1, 1, 1, 5, 6, 16'h0,    0, 16'h0,    16'h0));
    vq.push_back(mk(1, 5, 6, 1, 2, 16'h2222, 1, 1, 1, 5, 6, 16'h0,    1, 16'h0,    16'h0));
    vq.push_back(mk(1, 5, 6, 1, 4, 16'h4444, 0, 0, 0, 1, 0, 16'h1111, 1, 16'h0,    16'h0));
    vq.push_back(mk(1, 5, 6, 1, 4, 16'h4444, 1, 1, 1, 5, 6, 16'h0,    0, 16'h0,    16'h0));
    vq.push_back(mk(1, 5, 6, 0, 0, 16'h0,    0, 0, 0, 2, 0, 16'h2222, 1, 16'h0,    16'h0));
    vq.push_back(mk(1, 1, 2, 0, 0, 16'h0,    1, 1, 1, 1, 2, 16'h0,    0, 16'h0,    16'h0));
    vq.push_back(mk(1, 4, 2, 0, 0, 16'h0,    0, 1, 0, 4, 0, 16'h4444, 1, 16'h1111, 16'h2222));
    vq.push_back(mk(1, 4, 2, 0, 0, 16'h0,    1, 1, 1, 4, 2, 16'h0,    0, 16'h0,    16'h0));
    vq.push_back(mk(0, 0, 0, 0, 0, 16'h0,    0, 1, 1, 0, 0, 16'h0,    1, 16'h4444, 16'h2222));
    vq.push_back(mk(0, 0, 0, 1, 5, 16'hBEEF, 0, 1, 1, 0, 0, 16'h0,    0, 16'h0,    16'h0));
    vq.push_back(mk(0, 0, 0, 1, 6, 16'h0042, 0, 1, 0, 5, 0, 16'hBEEF, 0, 16'h0,    16'h0));
    vq.push_back(mk(0, 0, 0, 0, 0, 16'h0,    0, 1, 0, 6, 0, 16'h0042, 0, 16'h0,    16'h0));
    vq.push_back(mk(1, 5, 6, 0, 0, 16'h0,    1, 1, 1, 5, 6, 16'h0,    0, 16'h0,    16'h0));
    vq.push_back(mk(1, 6, 5, 0, 0, 16'h0,    1, 1, 1, 6, 5, 16'h0,    1, 16'hBEEF, 16'h0042));
    vq.push_back(mk(0, 0, 0, 0, 0, 16'h0,    0, 1, 1, 0, 0, 16'h0,    1, 16'h0042, 16'hBEEF));
    vq.push_back(mk(0, 0, 0, 0, 0, 16'h0,    0, 1, 1, 0, 0, 16'h0,    0, 16'h0,    16'h0));
    vq.push_back(mk(0, 0, 0, 1, 7, 16'h7777, 0, 1, 1, 0, 0, 16'h0,    0, 16'h0,    16'h0));
    vq.push_back(mk(1, 0, 7, 0, 0, 16'h0,    0, 1, 0, 7, 0, 16'h7777, 0, 16'h0,    16'h0));
    vq.push_back(mk(1, 0, 7, 0, 0, 16'h0,    1, 1, 1, 0, 7, 16'h0,    0, 16'h0,    16'h0));
    vq.push_back(mk(0, 0, 0, 0, 0, 16'h0,    0, 1, 1, 0, 0, 16'h0,    1, 16'h0,    16'h7777));

    // Reset held with a read pending: nothing may be granted.
    reset_n = 1'b0;
    drive(1, 3, 4, 1, 2, 16'h5555);
    #2;
    chk("reset rd_req_ready", 16'(bus.rd_req_ready), 16'h0);
    chk("reset wb_ready", 16'(bus.wb_ready), 16'h0);
    chk("reset rf_readflag", 16'(bus.rf_readflag), 16'h1);
    chk("reset rf_rs", 16'(bus.rf_rs), 16'h0);
    chk("reset rf_rd", 16'(bus.rf_rd), 16'h0);
    chk("reset rf_value", bus.rf_value, 16'h0);
    chk("reset rd_rsp_valid", 16'(bus.rd_rsp_valid), 16'h0);
    repeat (2) @(posedge clock);
    #1;
    drive(0, 0, 0, 0, 0, 16'h0);
    reset_n = 1'b1;

    for (int i = 0; i < 10; i++) begin
      #4;
      chk("idle rf_readflag", 16'(bus.rf_readflag), 16'h1);
      chk("idle rd_rsp_valid", 16'(bus.rd_rsp_valid), 16'h0);
      chk("idle wb_ready", 16'(bus.wb_ready), 16'h1);
      @(posedge clock);
      #1;
    end
    for (int r = 0; r < 8; r++) chk("idle regs", regs[r], 16'h0);

    foreach (vq[i]) begin
      step = i;
      drive(vq[i].rv, vq[i].a, vq[i].b, vq[i].wv, vq[i].wa, vq[i].wd);
      #4;
      check_port(vq[i]);
      @(posedge clock);
      #1;
    end

    // Fill the queue behind reads, then reset while a write is pending.
    step = 100;
    drive(1, 5, 6, 1, 1, 16'hAAAA);
    @(posedge clock);
    #1;
    drive(1, 5, 6, 1, 2, 16'hBBBB);
    @(posedge clock);
    #1;
    drive(0, 0, 0, 0, 0, 16'h0);
    #1;
    chk("full wb_ready", 16'(bus.wb_ready), 16'h0);
    chk("full rf_readflag", 16'(bus.rf_readflag), 16'h0);
    chk("full rf_rs", 16'(bus.rf_rs), 16'h1);
    chk("full rd_rsp_valid", 16'(bus.rd_rsp_valid), 16'h1);
    #1;
    reset_n = 1'b0;
    #1;
    chk("midreset wb_ready", 16'(bus.wb_ready), 16'h0);
    chk("midreset rf_readflag", 16'(bus.rf_readflag), 16'h1);
    chk("midreset rf_rs", 16'(bus.rf_rs), 16'h0);
    chk("midreset rf_value", bus.rf_value, 16'h0);
    chk("midreset rd_rsp_valid", 16'(bus.rd_rsp_valid), 16'h0);
    @(posedge clock);
    #1;
    reset_n = 1'b1;
    #3;
    chk("release wb_ready", 16'(bus.wb_ready), 16'h1);
    chk("release rf_readflag", 16'(bus.rf_readflag), 16'h1);
    @(posedge clock);
    #4;
    chk("drained rf_readflag", 16'(bus.rf_readflag), 16'h1);
    chk("r1 kept", regs[1], 16'h1111);
    chk("r2 kept", regs[2], 16'h2222);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
